// File: rtl/multicycle_main_control.sv
// Main control FSM for a multicycle MIPS-style datapath.
// Moore outputs decode from the state register; pc_en also folds in the ALU zero flag.
module multicycle_main_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BNE   = 6'b000101,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BNE     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_e;

  state_e state_q, state_d;

  logic ir_write_s, pc_write_s, pc_write_cond_s, mem_write_s, reg_write_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXEC;
        else if (opcode == OP_BNE)              state_d = S_BNE;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEX;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_ILLEGAL;
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    alu_op          = 2'b00;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    pc_source       = 2'b00;
    i_or_d          = 1'b0;
    mem_read        = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    reg_write_s     = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    illegal_op      = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE:  alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write_s = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEMWR: begin
        mem_write_s = 1'b1;
        i_or_d      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RWB: begin
        reg_write_s = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BNE: begin
        alu_src_a       = 1'b1;
        alu_op          = 2'b01;
        pc_source       = 2'b01;
        pc_write_cond_s = 1'b1;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB:  reg_write_s = 1'b1;
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write_s = 1'b1;
      end
      S_ILLEGAL: illegal_op = 1'b1;
      default: ;
    endcase
  end

  // Write strobes are masked by reset so they drop asynchronously, not at the next edge.
  assign ir_write  = reset_n & ir_write_s;
  assign mem_write = reset_n & mem_write_s;
  assign reg_write = reset_n & reg_write_s;
  assign pc_en     = reset_n & (pc_write_s | (pc_write_cond_s & ~zero));
  assign state     = state_q;

endmodule

// File: doc/multicycle_main_control.md
MULTICYCLE_MAIN_CONTROL -- requirements
Module: multicycle_main_control

Interface
REQ-001 Parameter: OP_RTYPE, 6'b000000, R-type opcode; OP_LW 6'b100011; OP_SW 6'b101011; OP_BNE 6'b000101; OP_ADDI 6'b001000; OP_J 6'b000010.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction[31:26], valid from DECODE onward.
REQ-005 zero  input  1  ALU zero flag, sampled combinationally in BNE state.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-007 alu_op  output  2  00 add, 01 sub, 10 use funct; drives the ALU control decoder.
REQ-008 alu_src_a  output  1  0 PC, 1 register A.
REQ-009 alu_src_b  output  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
REQ-010 pc_source  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 pc_en  output  1  PC load enable = pc_write | (pc_write_cond & ~zero).
REQ-012 i_or_d, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg  output  1 each  standard datapath strobes.
REQ-013 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-014 state  output  4  current state encoding, for debug/verification.

Function
REQ-015 Moore FSM; all outputs except pc_en decode from state register plus mem_ready only; unlisted outputs are 0 in every state.
REQ-016 Encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BNE 8, ADDIEX 9, ADDIWB 10, JUMP 11, ILLEGAL 12; codes 13-15 go to FETCH next cycle, all outputs 0.
REQ-017 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00; ir_write and pc_write = mem_ready; stay while mem_ready=0, else DECODE.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next: LW/SW->MEMADR, RTYPE->EXEC, BNE->BNE, ADDI->ADDIEX, J->JUMP, other->ILLEGAL.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEMRD if opcode=LW, else MEMWR.
REQ-020 MEMRD: mem_read=1, i_or_d=1; stay while mem_ready=0, else MEMWB.
REQ-021 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-022 MEMWR: mem_write=1, i_or_d=1; stay while mem_ready=0, else FETCH; mem_write held high throughout the wait.
REQ-023 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next RWB. RWB: reg_write=1, reg_dst=1, mem_to_reg=0; next FETCH.
REQ-024 BNE: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, pc_write_cond=1; next FETCH; PC loads only when zero=0.
REQ-025 ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDIWB. ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; next FETCH.
REQ-026 JUMP: pc_source=10, pc_write=1; next FETCH.
REQ-027 ILLEGAL: illegal_op=1 for exactly one cycle; no register/memory/PC writes; next FETCH.
REQ-028 Cycle counts with mem_ready=1: LW 5, SW 4, R-type 4, ADDI 4, BNE 3, J 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
REQ-029 opcode changes outside DECODE/MEMADR have no effect.
REQ-030 mem_write and reg_write never high in the same cycle; mem_read and mem_write never high together.

Reset
REQ-031 reset_n=0 forces state=FETCH immediately (asynchronous), independent of clk.
REQ-032 During reset all outputs 0 except FETCH static values (mem_read=1, alu_src_b=01); ir_write, pc_write, pc_en, mem_write, reg_write forced 0 while reset_n=0.
REQ-033 Reset asserted mid-instruction (e.g. in MEMWR) aborts it; mem_write drops asynchronously; first edge after release runs FETCH.

Verification
REQ-034 Reset release, opcode=LW, mem_ready=1 -> state 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-035 opcode=SW, mem_ready low 3 cycles in MEMWR -> state 5 held 4 cycles, mem_write=1 all 4, then FETCH.
REQ-036 opcode=BNE, zero=1 -> pc_en=0 in state 8; repeat with zero=0 -> pc_en=1, pc_source=01, alu_op=01.
REQ-037 opcode=RTYPE -> alu_op=10 in EXEC, reg_write=1 with reg_dst=1 in RWB, 4 cycles total.
REQ-038 opcode=6'b111111 -> DECODE, ILLEGAL (illegal_op=1 one cycle, no write strobes), FETCH.
REQ-039 reset_n pulsed low mid-cycle in MEMRD -> state=0 before next edge, no reg_write, then normal fetch.
